rv_bringup_ctrl: RTL and testbench
==================================

Name: rv_bringup_ctrl

Overview:
Synthesizable bring-up controller for rv_cpu. It sequences the CPU reset, bounds the run length, and runs a retirement watchdog. It also captures a circular trace of the most recent (PC, instruction) pairs for readback. It sits beside rv_cpu in bring-up tops (sim and FPGA) and replaces ad-hoc testbench reset/timeout/monitor code.

Parameters:
XLEN, 32, width of PC and instruction.
RST_CYCLES, 5, cycles cpu_rst is held high in RESET (>=1).
RUN_CYCLES, 50, RUN length in cycles; 0 = unlimited.
WDOG_CYCLES, 1000, max consecutive RUN cycles without pc_write before TIMEOUT (>=1).
TRACE_DEPTH, 16, trace entries; power of 2, >=2.
CNT_W, 32, width of cycle/retire counters.

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-low reset
start  in  1  level; begins a session from IDLE/DONE/TIMEOUT
halt_req  in  1  CPU halt indication (e.g. ebreak retired)
cpu_rst  out  1  active-high reset to rv_cpu
pc_write  in  1  CPU PC update strobe (one retirement)
pc  in  XLEN  CPU PC_out
instr  in  XLEN  CPU instruction-memory output
trace_rd_en  in  1  pop oldest trace entry
trace_rd_data  out  2*XLEN  {pc, instr} of popped entry
trace_rd_valid  out  1  trace_rd_data valid (one-cycle pulse)
trace_count  out  $clog2(TRACE_DEPTH)+1  entries held
trace_empty  out  1  trace_count==0
trace_overflow  out  1  sticky; an entry was overwritten
state  out  3  current bringup_state_e
cycle_count  out  CNT_W  RUN cycles elapsed, saturating
retired_count  out  CNT_W  pc_write strobes seen in RUN, saturating
done  out  1  state==DONE
timeout  out  1  state==TIMEOUT

Behaviour:
- Reset (rst==0 at posedge): state=IDLE, cpu_rst=1, all counters 0, trace empty, trace_overflow=0, trace_rd_valid=0, trace_rd_data=0.
- cpu_rst is registered: 0 only while state==RUN, 1 otherwise.
- IDLE: start=1 -> RESET. Counters and trace are cleared on entry.
- RESET: holds exactly RST_CYCLES cycles, then -> RUN.
- RUN:
  - cycle_count increments every cycle.
  - The watchdog counter is cleared on pc_write and increments otherwise.
  - Exit priority, evaluated each cycle:
    1. halt_req -> DONE.
    2. Watchdog reaches WDOG_CYCLES -> TIMEOUT.
    3. cycle_count+1 == RUN_CYCLES (RUN_CYCLES != 0) -> DONE.
  - The pc_write in the exit cycle is still counted and traced.
- DONE / TIMEOUT: hold. Counters and trace are frozen. start=1 -> RESET with counters and trace cleared; trace_overflow is cleared too.
- start is ignored in RESET and RUN.
- Counters saturate at all-ones, with no wrap.
- Trace write: in RUN with pc_write=1, push {pc, instr}.
- Trace read: trace_rd_en && !trace_empty pops the oldest entry. trace_rd_data is updated and trace_rd_valid=1 on the next cycle. Reads are legal in any state. trace_rd_en on empty is ignored, with no valid pulse.
- Full, push without pop: the oldest entry is discarded (read ptr advances), count stays TRACE_DEPTH, trace_overflow<=1.
- Full, push with pop: the pop returns the oldest, the push is stored, count is unchanged, overflow is not set.
- Empty, push with pop: the pop is ignored, the push is stored, count becomes 1.
- Pointers wrap modulo TRACE_DEPTH.
- rst asserted mid-RUN: next cycle IDLE, cpu_rst=1, trace discarded.

Decomposition:
- Package rv_bringup_pkg:
  - typedef enum logic[2:0] bringup_state_e {IDLE, RESET, RUN, DONE, TIMEOUT}.
  - typedef struct packed trace_entry_t {pc, instr}, parameterised by XLEN via package localparam default 32.
- One sub-module: rv_trace_ring, the circular overwrite-oldest buffer with count/overflow. The FSM and counters stay in rv_bringup_ctrl.

Test Plan:
- Basic run (RUN_CYCLES=50, RST_CYCLES=5):
  - Stimulus: start pulse; pc_write every cycle, pc=0,4,8,...
  - cpu_rst high exactly 5 cycles after leaving IDLE.
  - DONE after 50 RUN cycles, with cycle_count=50 and retired_count=50.
- Overflow (TRACE_DEPTH=16, 20 retirements):
  - trace_count=16 and trace_overflow=1.
  - 16 pops return pc=0x10..0x4C in order, each valid one cycle after rd_en; then trace_empty=1.
- Watchdog (WDOG_CYCLES=8):
  - Stimulus: pc_write stops after 3 retirements.
  - TIMEOUT exactly 8 cycles after the last pc_write; cpu_rst=1; retired_count=3.
- Halt priority:
  - Stimulus: halt_req and watchdog expiry in the same cycle.
  - Required: state=DONE, not TIMEOUT.
- Full push+pop:
  - Stimulus: trace full; pop and push in the same cycle.
  - Count stays 16, overflow stays 0, popped data is the oldest entry.
- Mid-run reset:
  - Stimulus: rst=0 at RUN cycle 10.
  - Next cycle state=IDLE, cpu_rst=1, trace_count=0, counters 0.
  - A subsequent start restarts cleanly.

Source files
------------

// File: rtl/rv_bringup_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rv_bringup_pkg
// Description : Shared types for the rv_cpu bring-up controller: the session
//               state encoding and the packed {pc, instr} trace entry.
// Revision    : 1.0 - initial release
// ============================================================================
package rv_bringup_pkg;

  // Session state, also exported on the controller's state_o port.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RESET   = 3'd1,
    RUN     = 3'd2,
    DONE    = 3'd3,
    TIMEOUT = 3'd4
  } bringup_state_e;

  localparam int PKG_XLEN = 32;

  // One trace record; pc sits in the upper half of the packed word.
  typedef struct packed {
    logic [PKG_XLEN-1:0] pc;
    logic [PKG_XLEN-1:0] instr;
  } trace_entry_t;

endpackage
`default_nettype wire

// File: rtl/rv_bringup_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : rv_bringup_ctrl_if
// Description : Trace readback bus of the bring-up controller.
//               master : trace reader (drives trace_rd_en)
//               slave  : controller   (drives data, valid, count and flags)
//   trace_rd_en    pop the oldest entry
//   trace_rd_data  {pc, instr} of the popped entry
//   trace_rd_valid one-cycle pulse, cycle after an accepted pop
//   trace_count    entries held
//   trace_empty    trace_count == 0
//   trace_overflow sticky, an entry was overwritten
// Revision    : 1.0 - initial release
// ============================================================================
interface rv_bringup_ctrl_if #(
  parameter int XLEN        = 32,
  parameter int TRACE_DEPTH = 16
);
  localparam int TCNT_W = $clog2(TRACE_DEPTH) + 1;

  logic              trace_rd_en;
  logic [2*XLEN-1:0] trace_rd_data;
  logic              trace_rd_valid;
  logic [TCNT_W-1:0] trace_count;
  logic              trace_empty;
  logic              trace_overflow;

  modport master (
    output trace_rd_en,
    input  trace_rd_data, trace_rd_valid, trace_count, trace_empty, trace_overflow
  );

  modport slave (
    input  trace_rd_en,
    output trace_rd_data, trace_rd_valid, trace_count, trace_empty, trace_overflow
  );
endinterface
`default_nettype wire

// File: rtl/rv_trace_ring.sv
`default_nettype none
// ============================================================================
// Module      : rv_trace_ring
// Description : Circular trace buffer that overwrites its oldest entry when
//               full. Pops return data one cycle later with a valid pulse.
//   clk, rst       clock, synchronous active-low reset
//   clear_i        empty the buffer and clear the overflow flag
//   push_i/data_i  store an entry
//   pop_i          pop the oldest entry (ignored when empty)
//   rd_data_o      popped entry, rd_valid_o pulses with it
//   count_o        entries held, empty_o, overflow_o (sticky)
// Revision    : 1.0 - initial release
// ============================================================================
module rv_trace_ring #(
  parameter int W     = 64,
  parameter int DEPTH = 16
) (
  input  wire logic                     clk,
  input  wire logic                     rst,
  input  wire logic                     clear_i,
  input  wire logic                     push_i,
  input  wire logic [W-1:0]             push_data_i,
  input  wire logic                     pop_i,
  output logic      [W-1:0]             rd_data_o,
  output logic                          rd_valid_o,
  output logic      [$clog2(DEPTH):0]   count_o,
  output logic                          empty_o,
  output logic                          overflow_o
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int TCNT_W = PTR_W + 1;

  logic [W-1:0]      mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [TCNT_W-1:0] count_q;
  logic              ovf_q, valid_q;
  logic [W-1:0]      data_q;

  logic full, push_ok, pop_ok;

  assign full    = (count_q == TCNT_W'(DEPTH));
  assign push_ok = push_i && !clear_i;
  assign pop_ok  = pop_i && (count_q != '0) && !clear_i;

  // Storage needs no reset; count and pointers define what is live.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      valid_q  <= 1'b0;
      data_q   <= '0;
    end else if (clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      valid_q <= pop_ok;
      if (pop_ok) data_q <= mem_q[rd_ptr_q];
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      // A push into a full ring discards the oldest entry; when a pop happens
      // in the same cycle that pop already consumed it, so advance only once.
      if (pop_ok || (push_ok && full)) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push_ok && full && !pop_ok) ovf_q <= 1'b1;
      if (push_ok && !pop_ok && !full)
        count_q <= count_q + 1'b1;
      else if (pop_ok && !push_ok)
        count_q <= count_q - 1'b1;
    end
  end

  assign rd_data_o  = data_q;
  assign rd_valid_o = valid_q;
  assign count_o    = count_q;
  assign empty_o    = (count_q == '0);
  assign overflow_o = ovf_q;
endmodule
`default_nettype wire

// File: rtl/rv_bringup_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : rv_bringup_ctrl
// Description : Bring-up controller for rv_cpu: sequences the CPU reset,
//               bounds the run length, watches retirement progress and keeps
//               a trace of the most recent (pc, instr) pairs.
//   clk, rst        clock, synchronous active-low reset
//   start_i         level, begins a session from IDLE/DONE/TIMEOUT
//   halt_req_i      CPU halt indication
//   cpu_rst_o       active-high reset to rv_cpu, low only in RUN
//   pc_write_i      one retirement; pc_i/instr_i traced with it
//   trace_if        trace readback bus (slave side)
//   state_o         bringup_state_e
//   cycle_count_o   RUN cycles, retired_count_o retirements (saturating)
//   done_o, timeout_o  session end flags
// Revision    : 1.0 - initial release
// ============================================================================
module rv_bringup_ctrl
  import rv_bringup_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int RST_CYCLES  = 5,
  parameter int RUN_CYCLES  = 50,
  parameter int WDOG_CYCLES = 1000,
  parameter int TRACE_DEPTH = 16,
  parameter int CNT_W       = 32
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             start_i,
  input  wire logic             halt_req_i,
  output logic                  cpu_rst_o,
  input  wire logic             pc_write_i,
  input  wire logic [XLEN-1:0]  pc_i,
  input  wire logic [XLEN-1:0]  instr_i,
  rv_bringup_ctrl_if.slave      trace_if,
  output logic      [2:0]       state_o,
  output logic      [CNT_W-1:0] cycle_count_o,
  output logic      [CNT_W-1:0] retired_count_o,
  output logic                  done_o,
  output logic                  timeout_o
);
  localparam int RST_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam int WD_W  = $clog2(WDOG_CYCLES + 1);

  bringup_state_e   state_q;
  logic             cpu_rst_q;
  logic [RST_W-1:0] rcnt_q;
  logic [WD_W-1:0]  wdog_q, wdog_d;
  logic [CNT_W-1:0] cycle_q, cycle_d, ret_q, ret_d;

  logic [CNT_W:0]   cycle_inc;
  logic [WD_W:0]    wdog_inc;
  logic             start_ok, push, wdog_exit, run_exit;

  assign start_ok  = start_i && (state_q == IDLE || state_q == DONE || state_q == TIMEOUT);
  assign push      = (state_q == RUN) && pc_write_i;

  assign cycle_inc = {1'b0, cycle_q} + 1'b1;
  assign cycle_d   = (&cycle_q) ? cycle_q : cycle_inc[CNT_W-1:0];
  assign ret_d     = (pc_write_i && !(&ret_q)) ? ret_q + 1'b1 : ret_q;
  // Run length compares the post-increment count so DONE lands after exactly
  // RUN_CYCLES cycles; the extra bit keeps a saturated count from matching.
  assign run_exit  = (RUN_CYCLES != 0) && (cycle_inc == (CNT_W+1)'(RUN_CYCLES));

  assign wdog_inc  = {1'b0, wdog_q} + 1'b1;
  assign wdog_d    = pc_write_i ? '0 : wdog_inc[WD_W-1:0];
  assign wdog_exit = !pc_write_i && (wdog_inc == (WD_W+1)'(WDOG_CYCLES));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      cpu_rst_q <= 1'b1;
      rcnt_q    <= '0;
      wdog_q    <= '0;
      cycle_q   <= '0;
      ret_q     <= '0;
    end else begin
      case (state_q)
        IDLE, DONE, TIMEOUT: begin
          if (start_i) begin
            state_q   <= RESET;
            cpu_rst_q <= 1'b1;
            rcnt_q    <= '0;
            wdog_q    <= '0;
            cycle_q   <= '0;
            ret_q     <= '0;
          end
        end
        RESET: begin
          if (rcnt_q == RST_W'(RST_CYCLES - 1)) begin
            state_q   <= RUN;
            cpu_rst_q <= 1'b0;
          end else begin
            rcnt_q <= rcnt_q + 1'b1;
          end
        end
        RUN: begin
          cycle_q <= cycle_d;
          ret_q   <= ret_d;
          wdog_q  <= wdog_d;
          if (halt_req_i) begin
            state_q   <= DONE;
            cpu_rst_q <= 1'b1;
          end else if (wdog_exit) begin
            state_q   <= TIMEOUT;
            cpu_rst_q <= 1'b1;
          end else if (run_exit) begin
            state_q   <= DONE;
            cpu_rst_q <= 1'b1;
          end
        end
        default: begin
          state_q   <= IDLE;
          cpu_rst_q <= 1'b1;
        end
      endcase
    end
  end

  rv_trace_ring #(
    .W     (2*XLEN),
    .DEPTH (TRACE_DEPTH)
  ) u_ring (
    .clk         (clk),
    .rst         (rst),
    .clear_i     (start_ok),
    .push_i      (push),
    .push_data_i ({pc_i, instr_i}),
    .pop_i       (trace_if.trace_rd_en),
    .rd_data_o   (trace_if.trace_rd_data),
    .rd_valid_o  (trace_if.trace_rd_valid),
    .count_o     (trace_if.trace_count),
    .empty_o     (trace_if.trace_empty),
    .overflow_o  (trace_if.trace_overflow)
  );

  assign cpu_rst_o       = cpu_rst_q;
  assign state_o         = state_q;
  assign cycle_count_o   = cycle_q;
  assign retired_count_o = ret_q;
  assign done_o          = (state_q == DONE);
  assign timeout_o       = (state_q == TIMEOUT);
endmodule
`default_nettype wire

// File: tb/tb_rv_bringup_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_rv_bringup_ctrl
// Description : Self-checking bench for rv_bringup_ctrl: directed sessions
//               plus randomized traffic against a queue-based reference.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rv_bringup_ctrl;
  import rv_bringup_pkg::*;

  localparam int XLEN   = 32;
  localparam int RST_C  = 5;
  localparam int RUN_C  = 50;
  localparam int WDOG_C = 8;
  localparam int DEPTH  = 16;
  localparam int CNT_W  = 32;
  localparam longint unsigned CMAX = (64'd1 << CNT_W) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst, start, halt_req, pc_write;
  logic [XLEN-1:0] pc, instr;
  logic            cpu_rst, done, timeout;
  logic [2:0]      state;
  logic [CNT_W-1:0] cycle_count, retired_count;

  rv_bringup_ctrl_if #(.XLEN(XLEN), .TRACE_DEPTH(DEPTH)) tif ();

  rv_bringup_ctrl #(
    .XLEN(XLEN), .RST_CYCLES(RST_C), .RUN_CYCLES(RUN_C),
    .WDOG_CYCLES(WDOG_C), .TRACE_DEPTH(DEPTH), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .start_i(start), .halt_req_i(halt_req),
    .cpu_rst_o(cpu_rst), .pc_write_i(pc_write), .pc_i(pc), .instr_i(instr),
    .trace_if(tif), .state_o(state), .cycle_count_o(cycle_count),
    .retired_count_o(retired_count), .done_o(done), .timeout_o(timeout)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  bringup_state_e    m_state;
  bit                m_cpu_rst, m_ovf, m_rd_valid;
  longint unsigned   m_cyc, m_ret;
  int                m_quiet, m_rst_left;
  logic [63:0]       m_q[$];
  logic [63:0]       m_rd_data;

  task automatic model_step();
    bit clear, pop, push;
    if (!rst) begin
      m_state = IDLE; m_cpu_rst = 1; m_cyc = 0; m_ret = 0; m_quiet = 0;
      m_rst_left = 0; m_q.delete(); m_ovf = 0; m_rd_valid = 0; m_rd_data = '0;
      return;
    end
    clear = start && (m_state inside {IDLE, DONE, TIMEOUT});
    push  = (m_state == RUN) && pc_write;
    if (clear) begin
      m_q.delete(); m_ovf = 0; m_rd_valid = 0;
    end else begin
      pop = tif.trace_rd_en && (m_q.size() > 0);
      m_rd_valid = pop;
      if (pop) m_rd_data = m_q.pop_front();
      if (push) begin
        if (m_q.size() == DEPTH) begin
          void'(m_q.pop_front());
          m_ovf = 1;
        end
        m_q.push_back({pc, instr});
      end
    end
    case (m_state)
      IDLE, DONE, TIMEOUT: if (start) begin
        m_state = RESET; m_rst_left = RST_C; m_cyc = 0; m_ret = 0; m_quiet = 0;
      end
      RESET: begin
        m_rst_left--;
        if (m_rst_left == 0) m_state = RUN;
      end
      RUN: begin
        if (m_cyc < CMAX) m_cyc++;
        if (pc_write && m_ret < CMAX) m_ret++;
        m_quiet = pc_write ? 0 : m_quiet + 1;
        if (halt_req)                          m_state = DONE;
        else if (m_quiet >= WDOG_C)            m_state = TIMEOUT;
        else if (RUN_C != 0 && m_cyc == RUN_C) m_state = DONE;
      end
      default: m_state = IDLE;
    endcase
    m_cpu_rst = (m_state != RUN);
  endtask

  task automatic check_all();
    check("state", state, m_state);
    check("cpu_rst", cpu_rst, m_cpu_rst);
    check("cycle_count", cycle_count, m_cyc);
    check("retired_count", retired_count, m_ret);
    check("done", done, m_state == DONE);
    check("timeout", timeout, m_state == TIMEOUT);
    check("trace_count", tif.trace_count, m_q.size());
    check("trace_empty", tif.trace_empty, m_q.size() == 0);
    check("trace_overflow", tif.trace_overflow, m_ovf);
    check("trace_rd_valid", tif.trace_rd_valid, m_rd_valid);
    check("trace_rd_data", tif.trace_rd_data, m_rd_data);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic wait_state(input bringup_state_e s, input int budget);
    int n = 0;
    while (state !== s && n < budget) begin
      tick();
      n++;
    end
    check($sformatf("wait_%s", s.name()), state, s);
  endtask

  task automatic begin_session();
    start = 1; tick(); start = 0;
    wait_state(RUN, 20);
  endtask

  task automatic retire(input logic [XLEN-1:0] a, input logic h);
    pc_write = 1; pc = a; instr = $urandom; halt_req = h;
    tick();
    pc_write = 0; halt_req = 0;
  endtask

  trace_entry_t e;
  int n;

  initial begin
    #1ms;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst = 0; start = 0; halt_req = 0; pc_write = 0; pc = '0; instr = '0;
    tif.trace_rd_en = 0;
    tick(); tick();
    check("rst_state", state, IDLE);
    check("rst_cpu_rst", cpu_rst, 1);
    check("rst_rd_data", tif.trace_rd_data, 0);
    rst = 1;
    tick();

    // Basic run: reset length then 50 back-to-back retirements.
    start = 1; tick(); start = 0; n = 1;
    while (state !== RUN && n < 20) begin tick(); n++; end
    check("cpu_rst_len", n, RST_C + 1);
    for (int i = 0; i < RUN_C && state == RUN; i++) retire(4 * i, 0);
    check("basic_done", state, DONE);
    check("basic_cycles", cycle_count, 50);
    check("basic_retired", retired_count, 50);
    check("basic_cpu_rst", cpu_rst, 1);

    // Overflow: 20 retirements, halt on the last one, then drain.
    begin_session();
    for (int i = 0; i < 20; i++) retire(4 * i, i == 19);
    check("ovf_done", state, DONE);
    check("ovf_count", tif.trace_count, 16);
    check("ovf_flag", tif.trace_overflow, 1);
    check("ovf_retired", retired_count, 20);
    for (int i = 0; i < DEPTH; i++) begin
      tif.trace_rd_en = 1; tick(); tif.trace_rd_en = 0;
      check("ovf_pop_valid", tif.trace_rd_valid, 1);
      e = tif.trace_rd_data;
      check("ovf_pop_pc", e.pc, 32'h10 + 4 * i);
      tick();
      check("ovf_valid_pulse", tif.trace_rd_valid, 0);
    end
    check("ovf_empty", tif.trace_empty, 1);
    tif.trace_rd_en = 1; tick(); tif.trace_rd_en = 0;
    check("empty_pop_novalid", tif.trace_rd_valid, 0);

    // Watchdog: 3 retirements then silence.
    begin_session();
    for (int i = 0; i < 3; i++) retire(4 * i, 0);
    for (int i = 0; i < WDOG_C - 1; i++) tick();
    check("wdog_not_yet", state, RUN);
    tick();
    check("wdog_timeout", state, TIMEOUT);
    check("wdog_flag", timeout, 1);
    check("wdog_cpu_rst", cpu_rst, 1);
    check("wdog_retired", retired_count, 3);

    // Halt request in the same cycle the watchdog would expire.
    begin_session();
    retire(0, 0);
    for (int i = 0; i < WDOG_C - 1; i++) tick();
    halt_req = 1; tick(); halt_req = 0;
    check("halt_priority", state, DONE);

    // Full ring with simultaneous pop and push.
    begin_session();
    for (int i = 0; i < DEPTH; i++) retire(4 * i, 0);
    check("full_count", tif.trace_count, 16);
    tif.trace_rd_en = 1; retire(4 * DEPTH, 0); tif.trace_rd_en = 0;
    check("fpp_count", tif.trace_count, 16);
    check("fpp_ovf", tif.trace_overflow, 0);
    check("fpp_valid", tif.trace_rd_valid, 1);
    e = tif.trace_rd_data;
    check("fpp_oldest", e.pc, 0);
    halt_req = 1; tick(); halt_req = 0;

    // Reset in the middle of a run, then a clean restart.
    begin_session();
    for (int i = 0; i < 10; i++) retire(4 * i, 0);
    rst = 0; tick(); rst = 1;
    check("mid_state", state, IDLE);
    check("mid_cpu_rst", cpu_rst, 1);
    check("mid_trace", tif.trace_count, 0);
    check("mid_cycles", cycle_count, 0);
    check("mid_retired", retired_count, 0);
    begin_session();
    for (int i = 0; i < 4; i++) retire(4 * i, i == 3);
    check("restart_done", state, DONE);
    check("restart_retired", retired_count, 4);

    // Randomized traffic; the model checks every cycle.
    for (int blk = 0; blk < 8; blk++) begin
      int p;
      p = (blk % 3 == 0) ? 95 : (blk % 3 == 1) ? 60 : 15;
      for (int c = 0; c < 200; c++) begin
        rst             = ($urandom_range(0, 399) != 0);
        start           = ($urandom_range(0, 15) == 0);
        halt_req        = ($urandom_range(0, 79) == 0);
        pc_write        = ($urandom_range(0, 99) < p);
        pc              = $urandom;
        instr           = $urandom;
        tif.trace_rd_en = ($urandom_range(0, 3) == 0);
        tick();
      end
    end
    rst = 1; start = 0; halt_req = 0; pc_write = 0; tif.trace_rd_en = 0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
